phase_overlap_monitor: RTL and testbench



---
 rtl/phase_overlap_monitor.sv | 222 ++++++++++++++++++++++
 tb/tb_phase_overlap_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_overlap_monitor.sv
// Two-phase non-overlapping clock checker: flags overlap, short gaps and phase-order
// violations, and measures the phi1 period. Define PHASE_MON_SYNC_EN to synchronize phi1/phi2.
module phase_overlap_monitor #(
    parameter int CNT_W   = 16,
    parameter int MIN_GAP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             phi1,
    input  logic             phi2,
    input  logic             clr_err,
    output logic             overlap_err,
    output logic             gap_err,
    output logic             order_err,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        G12,
        P2,
        G21
    } state_t;

    state_t state;
    state_t state_nxt;

    logic s1;
    logic s2;
    logic s1_q;
    logic s2_q;

`ifdef PHASE_MON_SYNC_EN
    logic [1:0] sync1;
    logic [1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sync1[0], phi1};
            sync2 <= {sync2[0], phi2};
        end
    end

    assign s1 = sync1[1];
    assign s2 = sync2[1];
`else
    assign s1 = phi1;
    assign s2 = phi2;
`endif

    logic rise1;
    logic rise2;
    logic fall1;
    logic fall2;
    logic both_low;
    logic both_high;

    assign rise1     = s1 & ~s1_q;
    assign rise2     = s2 & ~s2_q;
    assign fall1     = ~s1 & s1_q;
    assign fall2     = ~s2 & s2_q;
    assign both_low  = ~s1 & ~s2;
    assign both_high = s1 & s2;

    logic             armed;
    logic             have_p1;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             gap_short;

    assign gap_short = (gap_cnt < CNT_W'(MIN_GAP));

    logic set_ovl;
    logic set_gap;
    logic set_ord;
    logic p1_rise;
    logic report;
    logic gap_load;
    logic gap_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        set_ovl   = both_high;
        set_gap   = 1'b0;
        set_ord   = 1'b0;
        p1_rise   = 1'b0;
        report    = 1'b0;
        gap_load  = 1'b0;
        gap_inc   = 1'b0;

        case (state)
            IDLE: begin
                // First rise after IDLE only needs a preceding both-low sample, no gap check.
                if (armed && !both_high) begin
                    if (rise1) begin
                        state_nxt = P1;
                        p1_rise   = 1'b1;
                    end else if (rise2) begin
                        state_nxt = P2;
                    end
                end
            end
            P1: begin
                if (s2) begin
                    set_ovl   = 1'b1;
                    state_nxt = IDLE;
                end else if (fall1) begin
                    state_nxt = G12;
                    gap_load  = 1'b1;
                end
            end
            G12: begin
                if (both_high) begin
                    state_nxt = IDLE;
                end else if (rise2) begin
                    state_nxt = P2;
                    set_gap   = gap_short;
                end else if (rise1) begin
                    state_nxt = P1;
                    set_ord   = 1'b1;
                    p1_rise   = 1'b1;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            P2: begin
                if (s1) begin
                    set_ovl   = 1'b1;
                    state_nxt = IDLE;
                end else if (fall2) begin
                    state_nxt = G21;
                    gap_load  = 1'b1;
                end
            end
            G21: begin
                if (both_high) begin
                    state_nxt = IDLE;
                end else if (rise1) begin
                    state_nxt = P1;
                    set_gap   = gap_short;
                    p1_rise   = 1'b1;
                    report    = have_p1;
                end else if (rise2) begin
                    state_nxt = P2;
                    set_ord   = 1'b1;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            armed        <= 1'b0;
            have_p1      <= 1'b0;
            gap_cnt      <= '0;
            per_cnt      <= '0;
            overlap_err  <= 1'b0;
            gap_err      <= 1'b0;
            order_err    <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            s1_q <= s1;
            s2_q <= s2;

            if (state == IDLE && state_nxt == IDLE) begin
                armed <= armed | both_low;
            end else begin
                armed <= 1'b0;
            end

            if (state_nxt == IDLE) begin
                have_p1 <= 1'b0;
            end else if (p1_rise) begin
                have_p1 <= 1'b1;
            end

            // The falling-edge sample is itself the first both-low cycle of the gap.
            if (gap_load) begin
                gap_cnt <= CNT_W'(1);
            end else if (gap_inc && gap_cnt != '1) begin
                gap_cnt <= gap_cnt + CNT_W'(1);
            end

            if (p1_rise) begin
                per_cnt <= CNT_W'(1);
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end

            overlap_err <= set_ovl | (overlap_err & ~clr_err);
            gap_err     <= set_gap | (gap_err & ~clr_err);
            order_err   <= set_ord | (order_err & ~clr_err);

            period_valid <= report;
            if (report) begin
                period <= per_cnt;
            end
        end
    end

endmodule

// File: tb/tb_phase_overlap_monitor.sv
// Directed bench for phase_overlap_monitor: nominal period, overlap, gap, order,
// clear/error priority, mid-pulse reset and CNT_W=4 saturation.
module tb_phase_overlap_monitor;

`ifdef PHASE_MON_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        phi1;
    logic        phi2;
    logic        clr_err;
    logic        overlap_err;
    logic        gap_err;
    logic        order_err;
    logic [15:0] period;
    logic        period_valid;
    logic        overlap_err_s;
    logic        gap_err_s;
    logic        order_err_s;
    logic [3:0]  period_s;
    logic        period_valid_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    phase_overlap_monitor #(.CNT_W(16), .MIN_GAP(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .phi1         (phi1),
        .phi2         (phi2),
        .clr_err      (clr_err),
        .overlap_err  (overlap_err),
        .gap_err      (gap_err),
        .order_err    (order_err),
        .period       (period),
        .period_valid (period_valid)
    );

    phase_overlap_monitor #(.CNT_W(4), .MIN_GAP(2)) dut_small (
        .clk          (clk),
        .reset        (reset),
        .phi1         (phi1),
        .phi2         (phi2),
        .clr_err      (clr_err),
        .overlap_err  (overlap_err_s),
        .gap_err      (gap_err_s),
        .order_err    (order_err_s),
        .period       (period_s),
        .period_valid (period_valid_s)
    );

    // Pulse bookkeeping, sampled just after each active edge.
    int          pv_count  = 0;
    int          pv_double = 0;
    logic        pv_prev   = 1'b0;
    logic [15:0] last_period = '0;
    logic [3:0]  last_small  = '0;

    always @(posedge clk) begin
        #1;
        if (period_valid === 1'b1) begin
            pv_count    = pv_count + 1;
            last_period = period;
            if (pv_prev) pv_double = pv_double + 1;
        end
        if (period_valid_s === 1'b1) last_small = period_s;
        pv_prev = (period_valid === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            phi1 = a;
            phi2 = b;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    int         base;
    logic [3:0] lat_vec;

    initial begin
        reset   = 1'b1;
        phi1    = 1'b0;
        phi2    = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_overlap", overlap_err, 0);
        check("reset_gap", gap_err, 0);
        check("reset_order", order_err, 0);
        check("reset_period", period, 0);
        check("reset_valid", period_valid, 0);
        reset = 1'b0;

        // Nominal: 20 high, 5 gap, 20 high, 5 gap -> 50-cycle period.
        base = pv_count;
        for (int c = 0; c < 4; c++) begin
            hold(1, 0, 20); hold(0, 0, 5); hold(0, 1, 20); hold(0, 0, 5);
        end
        @(negedge clk);
        phi1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lat_vec[i] = period_valid;
        end
        check("latency_vec", lat_vec, 32'd1 << (LAT - 1));
        check("nominal_count", pv_count - base, 4);
        check("nominal_period", last_period, 50);
        check("saturated_period", last_small, 15);
        check("nominal_overlap", overlap_err, 0);
        check("nominal_gap", gap_err, 0);
        check("nominal_order", order_err, 0);

        // phi2 rises 10 cycles before phi1 falls.
        hold(1, 0, 5); hold(1, 1, 10);
        check("overlap_set", overlap_err, 1);
        hold(0, 1, 10); hold(0, 0, 5);
        base = pv_count;
        hold(1, 0, 20); hold(0, 0, 5); hold(0, 1, 20); hold(0, 0, 5);
        check("resync_no_period", pv_count - base, 0);
        hold(1, 0, 5);
        check("resync_count", pv_count - base, 1);
        check("resync_period", last_period, 50);
        check("resync_order", order_err, 0);

        pulse_clr();
        check("clr_overlap", overlap_err, 0);

        // One-cycle gap after phi1.
        base = pv_count;
        hold(1, 0, 13); hold(0, 0, 1); hold(0, 1, 23); hold(0, 0, 5); hold(1, 0, 5);
        check("short_gap_err", gap_err, 1);
        check("short_gap_period", last_period, 49);
        check("short_gap_count", pv_count - base, 1);

        // Gap exactly MIN_GAP is legal.
        pulse_clr();
        check("clr_gap", gap_err, 0);
        base = pv_count;
        hold(1, 0, 13); hold(0, 0, 2); hold(0, 1, 20); hold(0, 0, 2); hold(1, 0, 5);
        check("min_gap_ok", gap_err, 0);
        check("min_gap_period", last_period, 44);
        check("min_gap_count", pv_count - base, 1);
        check("min_gap_small", last_small, 15);

        // Two phi1 pulses with no phi2.
        hold(1, 0, 15); hold(0, 0, 5);
        base = pv_count;
        hold(1, 0, 10);
        check("order_set", order_err, 1);
        check("order_no_period", pv_count - base, 0);
        check("order_gap", gap_err, 0);
        pulse_clr();
        check("clr_order", order_err, 0);

        // clr_err coincides with the first overlap detection.
        @(negedge clk);
        phi2 = 1'b1;
        for (int i = 0; i < LAT - 1; i++) @(negedge clk);
        check("pre_overlap", overlap_err, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("error_beats_clr", overlap_err, 1);
        hold(0, 1, 5); hold(0, 0, 5);

        // Reset in the middle of phi1 high.
        hold(1, 0, 20); hold(0, 0, 5); hold(0, 1, 20); hold(0, 0, 5); hold(1, 0, 10);
        check("pre_reset_period", period, 50);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_overlap", overlap_err, 0);
        check("midreset_gap", gap_err, 0);
        check("midreset_order", order_err, 0);
        check("midreset_period", period, 0);
        check("midreset_valid", period_valid, 0);
        base = pv_count;
        hold(1, 0, 10); hold(0, 0, 5); hold(0, 1, 20); hold(0, 0, 5);
        hold(1, 0, 20); hold(0, 0, 5); hold(0, 1, 20); hold(0, 0, 5);
        check("post_reset_none", pv_count - base, 0);
        hold(1, 0, 5);
        check("post_reset_count", pv_count - base, 1);
        check("post_reset_period", last_period, 50);
        check("valid_single_cycle", pv_double, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
